// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and parameter defaults for the PWM decoder
package pwm_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} pwm_dec_state_t;
    localparam int PWM_DEC_CNT_W_DEFAULT = 16;
    localparam int PWM_DEC_TIMEOUT_DEFAULT = 1024;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: two-flop synchronizer plus delay flop giving level, rise and fall
module sync_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s0, s1, prev;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            prev <= 1'b0;
        end else begin
            s0 <= sig;
            s1 <= s0;
            prev <= s1;
        end
    end
    assign level = s1;
    assign rise = s1 & ~prev;
    assign fall = ~s1 & prev;
endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures high time and period of an asynchronous PWM input and flags a stuck line
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_DEC_CNT_W_DEFAULT,
    parameter int TIMEOUT = PWM_DEC_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             meas_valid,
    output logic             level_stuck,
    output logic             stuck_level
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    pwm_dec_state_t state, state_d;
    logic [CNT_W-1:0] ctr, ctr_d, high_tmp, high_tmp_d, high_count_d, period_count_d;
    logic meas_valid_d, level_stuck_d, stuck_level_d, expired;
    logic level, rise, fall;

    sync_edge_detect u_sync (
        .clk(clk),
        .reset_n(reset_n),
        .sig(pwm_in),
        .level(level),
        .rise(rise),
        .fall(fall)
    );

    always_comb begin
        state_d = state;
        ctr_d = ctr;
        high_tmp_d = high_tmp;
        high_count_d = high_count;
        period_count_d = period_count;
        meas_valid_d = 1'b0;
        level_stuck_d = level_stuck;
        stuck_level_d = stuck_level;
        expired = 1'b0;
        case (state)
            IDLE: begin
                ctr_d = '0;
                state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                expired = !rise && ctr == LIMIT;
                if (rise) begin
                    ctr_d = CNT_W'(1);
                    level_stuck_d = 1'b0;
                    state_d = HIGH;
                end else if (!level_stuck) begin
                    ctr_d = ctr + 1'b1;
                end
            end
            HIGH: begin
                expired = !fall && ctr == LIMIT;
                ctr_d = ctr + 1'b1;
                if (fall) begin
                    high_tmp_d = ctr;
                    state_d = LOW;
                end
            end
            LOW: begin
                expired = !rise && ctr == LIMIT;
                ctr_d = ctr + 1'b1;
                if (rise) begin
                    high_count_d = high_tmp;
                    period_count_d = ctr;
                    meas_valid_d = 1'b1;
                    ctr_d = CNT_W'(1);
                    state_d = HIGH;
                end
            end
        endcase
        // a timeout discards the partial period but keeps the last measurement
        if (expired) begin
            level_stuck_d = 1'b1;
            stuck_level_d = level;
            ctr_d = '0;
            state_d = WAIT_RISE;
        end
        if (!enable) begin
            state_d = IDLE;
            ctr_d = '0;
            level_stuck_d = 1'b0;
            meas_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            ctr <= '0;
            high_tmp <= '0;
            high_count <= '0;
            period_count <= '0;
            meas_valid <= 1'b0;
            level_stuck <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            state <= state_d;
            ctr <= ctr_d;
            high_tmp <= high_tmp_d;
            high_count <= high_count_d;
            period_count <= period_count_d;
            meas_valid <= meas_valid_d;
            level_stuck <= level_stuck_d;
            stuck_level <= stuck_level_d;
        end
    end
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed and random PWM waveforms checked against a timestamp-based period model
module tb_pwm_decoder;
    import pwm_pkg::*;

    typedef struct {
        int due;
        int h;
        int p;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n, enable, pwm_in;
    logic [15:0] high_count, period_count;
    logic meas_valid, level_stuck, stuck_level;

    int cyc = 0;
    int passed = 0;
    int failed = 0;
    int total = 0;
    exp_t q[$];
    int phase = 0;
    int r_t = 0;
    int f_t = 0;
    int last_h = 0;
    int last_p = 0;
    bit en_m = 0;

    pwm_decoder dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .pwm_in(pwm_in),
        .high_count(high_count),
        .period_count(period_count),
        .meas_valid(meas_valid),
        .level_stuck(level_stuck),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, expv);
        end
    endtask

    // one clock: every cycle meas_valid must match the model's schedule of reports
    task automatic step();
        exp_t e;
        bit exp_mv;
        @(posedge clk);
        #1;
        cyc++;
        exp_mv = q.size() > 0 && q[0].due == cyc;
        check("meas_valid", 32'(meas_valid), 32'(exp_mv));
        if (exp_mv) begin
            e = q.pop_front();
            last_h = e.h;
            last_p = e.p;
            check("high_count", 32'(high_count), e.h);
            check("period_count", 32'(period_count), e.p);
        end
    endtask

    // a rise closes the previous full period, reported three clocks after it is sampled
    task automatic set_pwm(input logic v);
        if (v !== pwm_in && en_m) begin
            if (v) begin
                if (phase == 2) q.push_back('{cyc + 3, f_t - r_t, cyc - r_t});
                r_t = cyc;
                phase = 1;
            end else if (phase == 1) begin
                f_t = cyc;
                phase = 2;
            end
        end
        pwm_in = v;
    endtask

    task automatic drive(input logic v, input int n);
        set_pwm(v);
        repeat (n) step();
    endtask

    task automatic period(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    initial begin
        int cuts[8] = '{1, 2, 4, 8, 16, 32, 128, 254};
        reset_n = 1'b0;
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (3) step();
        check("rst_high", 32'(high_count), 0);
        check("rst_period", 32'(period_count), 0);
        check("rst_valid", 32'(meas_valid), 0);
        check("rst_stuck", 32'(level_stuck), 0);
        check("rst_stuck_level", 32'(stuck_level), 0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        reset_n = 1'b1;
        enable = 1'b1;
        en_m = 1;
        phase = 0;
        drive(1'b0, 1100);
        check("stuck_low_flag", 32'(level_stuck), 1);
        check("stuck_low_level", 32'(stuck_level), 0);
        check("stuck_low_high", 32'(high_count), 0);
        set_pwm(1'b1);
        step();
        step();
        check("stuck_clear_early", 32'(level_stuck), 1);
        step();
        check("stuck_clear", 32'(level_stuck), 0);
        drive(1'b1, 37);
        drive(1'b0, 60);
        repeat (2) period(40, 60);
        drive(1'b1, 1100);
        phase = 0;
        check("stuck_high_flag", 32'(level_stuck), 1);
        check("stuck_high_level", 32'(stuck_level), 1);
        check("stuck_high_hold_h", 32'(high_count), 40);
        check("stuck_high_hold_p", 32'(period_count), 100);
        drive(1'b0, 20);
        check("stuck_fall_ignored", 32'(level_stuck), 1);
        repeat (6) period(64, 192);
        check("loop_high", 32'(high_count), 64);
        check("loop_period", 32'(period_count), 256);
        check("loop_stuck", 32'(level_stuck), 0);
        foreach (cuts[i]) begin
            repeat (2) period(cuts[i], 256 - cuts[i]);
            check("sweep_high", 32'(high_count), cuts[i]);
            check("sweep_period", 32'(period_count), 256);
        end
        repeat (20) period(int'($urandom_range(2, 200)), int'($urandom_range(2, 200)));
        drive(1'b0, 5);
        drive(1'b1, 20);
        enable = 1'b0;
        en_m = 0;
        phase = 0;
        step();
        check("dis_state", 32'(dut.state), 32'(IDLE));
        check("dis_stuck", 32'(level_stuck), 0);
        check("dis_hold_h", 32'(high_count), last_h);
        check("dis_hold_p", 32'(period_count), last_p);
        drive(1'b1, 10);
        drive(1'b0, 10);
        enable = 1'b1;
        en_m = 1;
        drive(1'b0, 5);
        repeat (3) period(30, 50);
        check("reen_high", 32'(high_count), 30);
        check("reen_period", 32'(period_count), 80);
        drive(1'b1, 30);
        drive(1'b0, 10);
        reset_n = 1'b0;
        step();
        check("mid_rst_high", 32'(high_count), 0);
        check("mid_rst_period", 32'(period_count), 0);
        check("mid_rst_valid", 32'(meas_valid), 0);
        check("mid_rst_stuck", 32'(level_stuck), 0);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        reset_n = 1'b1;
        phase = 0;
        last_h = 0;
        last_p = 0;
        drive(1'b0, 20);
        repeat (3) period(45, 80);
        check("post_rst_high", 32'(high_count), 45);
        check("post_rst_period", 32'(period_count), 125);
        repeat (5) step();
        check("queue_drained", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
